// File: rtl/mul16_pkg.sv
// Shared types and constants for the sequential 16x16 multiplier.
package mul16_pkg;

    localparam int WIDTH   = 16;
    localparam int COUNT_W = 4;

    localparam logic [COUNT_W-1:0] LAST_COUNT = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // True when either operand is zero, which makes the product trivially 0.
    function automatic logic is_zero_op(input logic [WIDTH-1:0] x,
                                        input logic [WIDTH-1:0] y);
        return (x == '0) || (y == '0);
    endfunction

endpackage

// File: rtl/add16.sv
// 16-bit ripple-carry adder; one full adder per bit, carry chained LSB to MSB.
module add16
    import mul16_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    // Ripple the carry through each bit position.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]     = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
        end
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/mul16_seq.sv
// Sequential 16x16 unsigned shift-add multiplier built around one add16.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; product holds the last result
//   RUN   | one add/shift step per cycle, 16 steps, busy=1
//   DONE  | done=1 for one cycle; product valid; start here re-accepts
module mul16_seq
    import mul16_pkg::*;
#(
    parameter bit ZERO_BYPASS = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [COUNT_W-1:0] count;

    logic               accept;
    logic               bypass;
    logic               last_step;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic [WIDTH-1:0]   hi_nxt;
    logic [WIDTH-1:0]   lo_nxt;

    // Start is only honoured when no operation is in flight.
    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign bypass    = ZERO_BYPASS && is_zero_op(a, b);
    assign last_step = (state == RUN) && (count == LAST_COUNT);

    // Add the multiplicand only when the current multiplier bit is set.
    assign addend = lo[0] ? mcand : '0;

    add16 u_add16 (
        .a    (hi),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // The 17-bit sum shifts right one place across {hi, lo}; cout becomes hi's MSB.
    assign hi_nxt = {cout, sum[WIDTH-1:1]};
    assign lo_nxt = {sum[0], lo[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; DONE accepts a back-to-back start under the same rules as IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = bypass ? DONE : RUN;
                end
            end
            RUN: begin
                if (count == LAST_COUNT) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt = bypass ? DONE : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs decoded from the state alone.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, shift-add steps and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            hi      <= '0;
            lo      <= '0;
            count   <= '0;
            product <= '0;
        end else if (accept) begin
            if (bypass) begin
                product <= '0;
            end else begin
                mcand <= a;
                lo    <= b;
                hi    <= '0;
                count <= '0;
            end
        end else if (state == RUN) begin
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            // Wraps 15 -> 0 on the final step, leaving it clean for the next run.
            count <= count + COUNT_W'(1);
            if (last_step) begin
                product <= {hi_nxt, lo_nxt};
            end
        end
    end

endmodule

// File: doc/mul16_seq.md
Name: mul16_seq

Overview:
- Multi-cycle 16x16 unsigned shift-add multiplier sequencer built around one instance of the existing 16-bit ripple adder (add16).
- Issues one add per cycle for 16 cycles and produces a 32-bit product.
- Sits beside the ALU as the multiply resource; a CPU or test harness drives it through a start/done handshake.

Parameters:
- ZERO_BYPASS, 1: when 1, an accepted start with a==0 or b==0 goes straight to DONE. Result is 0. Latency is 1 cycle instead of 17.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a multiply; sampled on a rising clk edge
- a  in  16  multiplicand; captured when start is accepted
- b  in  16  multiplier; captured when start is accepted
- busy  out  1  high while an operation is in progress (state RUN)
- done  out  1  one-cycle pulse: product is valid
- product  out  32  result; held stable from done until the next accepted start

Behaviour:
- Reset:
  - One clock; reset is asynchronous, active-low on rst_n.
  - On rst_n=0: state=IDLE; busy=0, done=0, product=0; internal registers (mcand, hi, lo, count) cleared.
  - Reset mid-RUN aborts the operation immediately; no done is issued.
- States:
  - IDLE: start=1 is accepted; go to RUN and capture mcand<=a, lo<=b, hi<=0, count<=0.
  - IDLE with ZERO_BYPASS=1 and (a==0 or b==0): go directly to DONE instead, with product<=0.
  - RUN: one step per cycle; count increments; after the step with count==15, go to DONE.
  - DONE: done=1 for exactly this cycle. Next state is IDLE, or RUN if start=1 (back-to-back accept, same capture rules as IDLE).
- Datapath step in RUN, per cycle:
  - add16 inputs: a=hi, b=(lo[0] ? mcand : 16'h0), cin=0; outputs sum and cout.
  - hi <= {cout, sum[15:1]}
  - lo <= {sum[0], lo[15:1]}
  - After 16 steps, {hi,lo} is the full unsigned product. No overflow is possible; cout is never dropped.
- Output timing:
  - product <= {next hi, next lo} on the final RUN edge, so product is valid in the same cycle done=1.
  - product is held until the next accepted start. On a new start it is not cleared; it simply updates at the next DONE.
- Latency:
  - Start sampled at edge k gives busy=1 for edges k..k+15 and done=1 in the cycle after edge k+16.
  - Total is 17 cycles from the start edge to the done cycle.
  - Zero bypass: done=1 in the cycle after edge k.
- Inputs and start during RUN:
  - start=1 during RUN is ignored, not queued.
  - a and b may change freely after acceptance.
- busy = (state==RUN); busy is 0 in IDLE and DONE.
- count is 4 bits; it wraps 15->0 at the RUN->DONE transition and has no other wrap.

Decomposition:
- Shared package/header mul16_pkg:
  - state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - constants WIDTH=16, COUNT_W=4, LAST_COUNT=4'd15
- Sub-module: the existing add16, instantiated once. No other sub-module is needed.
- The FSM, count and shift registers stay in mul16_seq.

Test Plan:
- Basic multiply: a=3, b=5, start pulse -> busy=1 for 16 cycles; done=1 in the 17th cycle after start with product=32'd15; busy=0 in that cycle.
- Maximum operands: a=16'hFFFF, b=16'hFFFF -> product=32'hFFFE0001 at done. Covers every add16 carry-out path.
- Zero bypass: ZERO_BYPASS=1, a=16'h1234, b=0 -> done one cycle after start, product=0, busy never high. With ZERO_BYPASS=0 -> 17-cycle latency, product=0.
- Start ignored in RUN: start a=7,b=9; pulse start again with a=2,b=2 at cycle 5 -> single done with product=63; no second done.
- Back-to-back: hold start=1 with a=16'h00FF, b=16'h0100 across DONE -> first product=32'h0000FF00. A second operation is accepted in the DONE cycle; its done follows 17 cycles later.
- Reset mid-op: assert rst_n=0 asynchronously at cycle 8 of RUN -> busy, done and product go to 0 immediately. After release: IDLE, no spurious done, and a new start a=10, b=10 gives product=100.
